node_pkt_tx: RTL and testbench

Outgoing-packet builder for the EER-RL node, the transmit side of the Q-table update path. On request it scans the local neighbor Q-value table in node memory and selects the best (maximum) Q-value to advertise. It then streams a packet as 16-bit words over a valid/ready interface: type, source ID, hops, cluster ID, energy, best Q-value, known-CH count, and the known-CH list read back from memory. Receiving nodes unpack this word stream into the f* fields their Q-table update logic consumes.

---
 rtl/node_pkt_tx.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_node_pkt_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_pkt_tx.sv
// node_pkt_tx
// Transmit side of the EER-RL Q-table update path. On a start request the
// block scans the local neighbor Q-value table in node memory, keeps the
// largest value (lowest index wins on ties), then streams a packet of
// 16-bit words over a valid/ready link:
//   type, myID, myHops, myClusterID, myEnergy, bestQ, knownCHCount,
//   followed by the known-CH list read back from memory.
// Ports:
//   clk, nrst           clock (rising edge), synchronous active-low reset
//   en                  start request, honoured only while idle
//   pktType, my*, neighborCount, knownCHCount  packet fields, captured on start
//   mem_rd_en/mem_addr  memory read strobe and address
//   mem_rdata           read data, valid one cycle after mem_rd_en
//   tx_data/tx_valid/tx_ready/tx_last  outgoing word stream
//   bestQ/bestIdx       result of the last scan (bestIdx all-ones if none)
//   busy, done          activity flag and end-of-packet pulse
module node_pkt_tx #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter logic [ADDR_WIDTH-1:0] QV_BASE  = 11'h100,
  parameter logic [ADDR_WIDTH-1:0] KCH_BASE = 11'h200
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [2:0]            pktType,
  input  logic [WORD_WIDTH-1:0] myID,
  input  logic [WORD_WIDTH-1:0] myHops,
  input  logic [WORD_WIDTH-1:0] myClusterID,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic [WORD_WIDTH-1:0] neighborCount,
  input  logic [WORD_WIDTH-1:0] knownCHCount,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic [WORD_WIDTH-1:0] bestQ,
  output logic [WORD_WIDTH-1:0] bestIdx,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN_REQ = 3'd1,
    SCAN_CMP = 3'd2,
    HDR      = 3'd3,
    KCH_REQ  = 3'd4,
    KCH_WAIT = 3'd5,
    KCH_SEND = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t state_r, nextState_s;

  logic [2:0]            pktType_r, pktType_s;
  logic [WORD_WIDTH-1:0] myID_r, myID_s, myHops_r, myHops_s;
  logic [WORD_WIDTH-1:0] myClusterID_r, myClusterID_s, myEnergy_r, myEnergy_s;
  logic [WORD_WIDTH-1:0] neighborCount_r, neighborCount_s, knownCHCount_r, knownCHCount_s;
  logic [WORD_WIDTH-1:0] bestQ_r, bestQ_s, bestIdx_r, bestIdx_s;
  logic [WORD_WIDTH-1:0] nCnt_r, nCnt_s, kCnt_r, kCnt_s;
  logic [2:0]            hdrIdx_r, hdrIdx_s;
  logic                  memRdEn_r, memRdEn_s;
  logic [ADDR_WIDTH-1:0] memAddr_r, memAddr_s;
  logic [WORD_WIDTH-1:0] txData_r, txData_s;
  logic                  txValid_r, txValid_s, txLast_r, txLast_s;
  logic                  busy_r, busy_s, done_r, done_s;

  // One bit wider than the counters so index+1 never wraps at 16'hFFFF.
  logic [WORD_WIDTH:0]   nPlus1_s, kPlus1_s;
  logic                  hs_s;

  assign nPlus1_s = {1'b0, nCnt_r} + {{WORD_WIDTH{1'b0}}, 1'b1};
  assign kPlus1_s = {1'b0, kCnt_r} + {{WORD_WIDTH{1'b0}}, 1'b1};
  assign hs_s     = txValid_r & tx_ready;

  // Header word selected by its position in the packet.
  function automatic logic [WORD_WIDTH-1:0] hdrWord(
    input logic [2:0]            idx,
    input logic [2:0]            typ,
    input logic [WORD_WIDTH-1:0] id,
    input logic [WORD_WIDTH-1:0] hops,
    input logic [WORD_WIDTH-1:0] cid,
    input logic [WORD_WIDTH-1:0] energy,
    input logic [WORD_WIDTH-1:0] bq,
    input logic [WORD_WIDTH-1:0] kc
  );
    case (idx)
      3'd0:    hdrWord = {{(WORD_WIDTH-3){1'b0}}, typ};
      3'd1:    hdrWord = id;
      3'd2:    hdrWord = hops;
      3'd3:    hdrWord = cid;
      3'd4:    hdrWord = energy;
      3'd5:    hdrWord = bq;
      3'd6:    hdrWord = kc;
      default: hdrWord = {WORD_WIDTH{1'b0}};
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) state_r <= IDLE;
    else       state_r <= nextState_s;
  end

  // Next-state decode.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (!en)                            nextState_s = IDLE;
        else if (neighborCount != {WORD_WIDTH{1'b0}}) nextState_s = SCAN_REQ;
        else                                nextState_s = HDR;
      end
      SCAN_REQ: nextState_s = SCAN_CMP;
      SCAN_CMP: begin
        if (nPlus1_s < {1'b0, neighborCount_r}) nextState_s = SCAN_REQ;
        else                                    nextState_s = HDR;
      end
      HDR: begin
        if (hs_s && (hdrIdx_r == 3'd6))
          nextState_s = (knownCHCount_r != {WORD_WIDTH{1'b0}}) ? KCH_REQ : DONE;
        else
          nextState_s = HDR;
      end
      KCH_REQ:  nextState_s = KCH_WAIT;
      KCH_WAIT: nextState_s = KCH_SEND;
      KCH_SEND: begin
        if (!hs_s)                                 nextState_s = KCH_SEND;
        else if (kPlus1_s < {1'b0, knownCHCount_r}) nextState_s = KCH_REQ;
        else                                       nextState_s = DONE;
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Captured fields, scan result and counters for the next cycle.
  always_comb begin
    pktType_s       = pktType_r;
    myID_s          = myID_r;
    myHops_s        = myHops_r;
    myClusterID_s   = myClusterID_r;
    myEnergy_s      = myEnergy_r;
    neighborCount_s = neighborCount_r;
    knownCHCount_s  = knownCHCount_r;
    bestQ_s         = bestQ_r;
    bestIdx_s       = bestIdx_r;
    nCnt_s          = nCnt_r;
    kCnt_s          = kCnt_r;
    hdrIdx_s        = hdrIdx_r;
    case (state_r)
      IDLE: begin
        if (en) begin
          pktType_s       = pktType;
          myID_s          = myID;
          myHops_s        = myHops;
          myClusterID_s   = myClusterID;
          myEnergy_s      = myEnergy;
          neighborCount_s = neighborCount;
          knownCHCount_s  = knownCHCount;
          bestQ_s         = {WORD_WIDTH{1'b0}};
          bestIdx_s       = {WORD_WIDTH{1'b1}};
          nCnt_s          = {WORD_WIDTH{1'b0}};
          kCnt_s          = {WORD_WIDTH{1'b0}};
          hdrIdx_s        = 3'd0;
        end else begin
          hdrIdx_s = hdrIdx_r;
        end
      end
      SCAN_CMP: begin
        // Strict compare keeps the lower index on ties; the first entry
        // always loads so a table of zeros still reports index 0.
        if ((mem_rdata > bestQ_r) || (bestIdx_r == {WORD_WIDTH{1'b1}})) begin
          bestQ_s   = mem_rdata;
          bestIdx_s = nCnt_r;
        end else begin
          bestQ_s   = bestQ_r;
        end
        nCnt_s = nPlus1_s[WORD_WIDTH-1:0];
      end
      HDR: begin
        if (hs_s) hdrIdx_s = hdrIdx_r + 3'd1;
        else      hdrIdx_s = hdrIdx_r;
      end
      KCH_SEND: begin
        if (hs_s) kCnt_s = kPlus1_s[WORD_WIDTH-1:0];
        else      kCnt_s = kCnt_r;
      end
      default: begin
        nCnt_s = nCnt_r;
      end
    endcase
  end

  // Output values, decoded from the state being entered so the ports
  // can come straight from flops.
  always_comb begin
    memRdEn_s = 1'b0;
    memAddr_s = memAddr_r;
    txData_s  = txData_r;
    txValid_s = 1'b0;
    txLast_s  = 1'b0;
    busy_s    = (nextState_s != IDLE);
    done_s    = (nextState_s == DONE);
    case (nextState_s)
      SCAN_REQ: begin
        memRdEn_s = 1'b1;
        memAddr_s = QV_BASE + nCnt_s[ADDR_WIDTH-1:0];
      end
      KCH_REQ: begin
        memRdEn_s = 1'b1;
        memAddr_s = KCH_BASE + kCnt_s[ADDR_WIDTH-1:0];
      end
      HDR: begin
        txValid_s = 1'b1;
        txData_s  = hdrWord(hdrIdx_s, pktType_s, myID_s, myHops_s, myClusterID_s,
                            myEnergy_s, bestQ_s, knownCHCount_s);
        txLast_s  = (hdrIdx_s == 3'd6) && (knownCHCount_s == {WORD_WIDTH{1'b0}});
      end
      KCH_SEND: begin
        txValid_s = 1'b1;
        // Read data is only present in KCH_WAIT; afterwards the word is held.
        if (state_r == KCH_WAIT) begin
          txData_s = mem_rdata;
          txLast_s = (kPlus1_s == {1'b0, knownCHCount_r});
        end else begin
          txData_s = txData_r;
          txLast_s = txLast_r;
        end
      end
      default: begin
        txValid_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pktType_r       <= 3'd0;
      myID_r          <= {WORD_WIDTH{1'b0}};
      myHops_r        <= {WORD_WIDTH{1'b0}};
      myClusterID_r   <= {WORD_WIDTH{1'b0}};
      myEnergy_r      <= {WORD_WIDTH{1'b0}};
      neighborCount_r <= {WORD_WIDTH{1'b0}};
      knownCHCount_r  <= {WORD_WIDTH{1'b0}};
      bestQ_r         <= {WORD_WIDTH{1'b0}};
      bestIdx_r       <= {WORD_WIDTH{1'b1}};
      nCnt_r          <= {WORD_WIDTH{1'b0}};
      kCnt_r          <= {WORD_WIDTH{1'b0}};
      hdrIdx_r        <= 3'd0;
      memRdEn_r       <= 1'b0;
      memAddr_r       <= {ADDR_WIDTH{1'b0}};
      txData_r        <= {WORD_WIDTH{1'b0}};
      txValid_r       <= 1'b0;
      txLast_r        <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      pktType_r       <= pktType_s;
      myID_r          <= myID_s;
      myHops_r        <= myHops_s;
      myClusterID_r   <= myClusterID_s;
      myEnergy_r      <= myEnergy_s;
      neighborCount_r <= neighborCount_s;
      knownCHCount_r  <= knownCHCount_s;
      bestQ_r         <= bestQ_s;
      bestIdx_r       <= bestIdx_s;
      nCnt_r          <= nCnt_s;
      kCnt_r          <= kCnt_s;
      hdrIdx_r        <= hdrIdx_s;
      memRdEn_r       <= memRdEn_s;
      memAddr_r       <= memAddr_s;
      txData_r        <= txData_s;
      txValid_r       <= txValid_s;
      txLast_r        <= txLast_s;
      busy_r          <= busy_s;
      done_r          <= done_s;
    end
  end

  assign mem_rd_en = memRdEn_r;
  assign mem_addr  = memAddr_r;
  assign tx_data   = txData_r;
  assign tx_valid  = txValid_r;
  assign tx_last   = txLast_r;
  assign bestQ     = bestQ_r;
  assign bestIdx   = bestIdx_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_node_pkt_tx.sv
// Self-checking bench for node_pkt_tx: memory model, word monitor and a
// packet-level reference model built from the packet format rules.
module tb_node_pkt_tx;
  logic        clk = 1'b0;
  logic        nrst, en;
  logic [2:0]  pktType;
  logic [15:0] myID, myHops, myClusterID, myEnergy, neighborCount, knownCHCount;
  logic        mem_rd_en;
  logic [10:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready, tx_last;
  logic [15:0] bestQ, bestIdx;
  logic        busy, done;

  node_pkt_tx dut (
    .clk(clk), .nrst(nrst), .en(en), .pktType(pktType), .myID(myID),
    .myHops(myHops), .myClusterID(myClusterID), .myEnergy(myEnergy),
    .neighborCount(neighborCount), .knownCHCount(knownCHCount),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .bestQ(bestQ), .bestIdx(bestIdx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  // Node memory: data appears one cycle after the strobe, garbage otherwise.
  logic [15:0] mem [0:2047];
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 16'hDEAD;

  // Monitor: accepted words, done pulses, reads, hold-stability.
  logic [15:0] gotWords[$];
  bit          gotLast[$];
  int          doneCount, qvReads, kchReads, stabErr, rdErr;
  logic        prevValid = 1'b0, prevReady = 1'b0, prevLast = 1'b0, prevRd = 1'b0;
  logic [15:0] prevData = 16'h0;
  always @(negedge clk) begin
    if (prevValid && !prevReady && (tx_valid !== 1'b1 || tx_data !== prevData || tx_last !== prevLast))
      stabErr <= stabErr + 1;
    if (prevRd && mem_rd_en) rdErr <= rdErr + 1;
    if (tx_valid && tx_ready) begin
      gotWords.push_back(tx_data);
      gotLast.push_back(tx_last);
    end
    if (done) doneCount <= doneCount + 1;
    if (mem_rd_en && mem_addr >= 11'h100 && mem_addr < 11'h200) qvReads <= qvReads + 1;
    if (mem_rd_en && mem_addr >= 11'h200 && mem_addr < 11'h300) kchReads <= kchReads + 1;
    prevValid <= tx_valid; prevReady <= tx_ready; prevLast <= tx_last;
    prevData  <= tx_data;  prevRd    <= mem_rd_en;
  end

  // Sink: 0 = always ready, 1 = 1-0-0-1 pattern, 2 = random, 3 = stalled.
  int readyMode = 0;
  int patIdx = 0;
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        0: tx_ready = 1'b1;
        1: begin tx_ready = ((patIdx % 4) == 0) || ((patIdx % 4) == 3); patIdx++; end
        2: tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Reference model.
  logic [15:0] qvVals[$], kchVals[$], expWords[$];
  bit          expLast[$];
  logic [15:0] expBestQ, expBestIdx;

  task automatic buildExp();
    logic [15:0] mx;
    mx = 16'h0;
    expBestQ = 16'h0; expBestIdx = 16'hFFFF;
    foreach (qvVals[i]) if (qvVals[i] > mx) mx = qvVals[i];
    for (int i = qvVals.size() - 1; i >= 0; i--)
      if (qvVals[i] == mx) begin expBestQ = mx; expBestIdx = 16'(i); end
    expWords = '{{13'd0, pktType}, myID, myHops, myClusterID, myEnergy,
                 expBestQ, 16'(kchVals.size())};
    foreach (kchVals[j]) expWords.push_back(kchVals[j]);
    expLast.delete();
    foreach (expWords[i]) expLast.push_back(i == expWords.size() - 1);
  endtask

  task automatic randomFields();
    pktType = 3'($urandom_range(0, 7)); myID = 16'($urandom); myHops = 16'($urandom);
    myClusterID = 16'($urandom); myEnergy = 16'($urandom);
  endtask

  task automatic clearMon();
    gotWords.delete(); gotLast.delete();
    doneCount = 0; qvReads = 0; kchReads = 0; stabErr = 0; rdErr = 0;
  endtask

  task automatic startPacket();
    neighborCount = 16'(qvVals.size());
    knownCHCount  = 16'(kchVals.size());
    foreach (qvVals[i])  mem[11'h100 + 11'(i)] = qvVals[i];
    foreach (kchVals[j]) mem[11'h200 + 11'(j)] = kchVals[j];
    buildExp();
    clearMon();
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1; en = 1'b0;
  endtask

  // Cycle 1 is the one following the edge that sampled en.
  task automatic waitDone(output int hdrCyc, output int doneCyc);
    int m;
    m = 0; hdrCyc = -1; doneCyc = -1;
    while (m < 3000) begin
      if (tx_valid && hdrCyc < 0) hdrCyc = m + 1;
      if (done) begin doneCyc = m + 1; break; end
      @(posedge clk); #1; m++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nChecks++; if (tx_valid !== 1'b0) begin nFail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    nChecks++; if (tx_data !== 16'h0) begin nFail++; $display("FAIL rst_tx_data: got %h want 0000", tx_data); end
    nChecks++; if (tx_last !== 1'b0) begin nFail++; $display("FAIL rst_tx_last: got %b want 0", tx_last); end
    nChecks++; if (mem_rd_en !== 1'b0) begin nFail++; $display("FAIL rst_rd_en: got %b want 0", mem_rd_en); end
    nChecks++; if (mem_addr !== 11'h0) begin nFail++; $display("FAIL rst_addr: got %h want 000", mem_addr); end
    nChecks++; if (bestQ !== 16'h0) begin nFail++; $display("FAIL rst_bestQ: got %h want 0000", bestQ); end
    nChecks++; if (bestIdx !== 16'hFFFF) begin nFail++; $display("FAIL rst_bestIdx: got %h want ffff", bestIdx); end
    nChecks++; if (busy !== 1'b0 || done !== 1'b0) begin nFail++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
  endtask

  task automatic test_basic();
    int h, d;
    qvVals = '{16'd10, 16'd40, 16'd40}; kchVals = {};
    randomFields(); startPacket(); waitDone(h, d);
    nChecks++; if (bestQ !== 16'd40 || bestIdx !== 16'd1) begin nFail++; $display("FAIL basic_best: got %h@%h want 0028@0001", bestQ, bestIdx); end
    nChecks++; if (gotWords.size() != 7) begin nFail++; $display("FAIL basic_count: got %0d want 7", gotWords.size()); end
    foreach (expWords[i]) begin
      nChecks++;
      if (i >= gotWords.size() || gotWords[i] !== expWords[i] || gotLast[i] !== expLast[i]) begin
        nFail++; $display("FAIL basic_word%0d: got %h/%0b want %h/%0b", i, gotWords[i], gotLast[i], expWords[i], expLast[i]);
      end
    end
    nChecks++; if (h != 7) begin nFail++; $display("FAIL basic_hdr_cycle: got %0d want 7", h); end
    nChecks++; if (d != 14) begin nFail++; $display("FAIL basic_done_cycle: got %0d want 14", d); end
    nChecks++; if (qvReads != 3 || rdErr != 0) begin nFail++; $display("FAIL basic_reads: got %0d/%0d want 3/0", qvReads, rdErr); end
  endtask

  task automatic test_no_neighbors();
    int h, d;
    qvVals = {}; kchVals = '{16'd5, 16'd9};
    randomFields(); pktType = 3'd3; startPacket(); waitDone(h, d);
    nChecks++; if (bestIdx !== 16'hFFFF || bestQ !== 16'h0) begin nFail++; $display("FAIL nonb_best: got %h@%h want 0000@ffff", bestQ, bestIdx); end
    nChecks++; if (gotWords.size() != 9) begin nFail++; $display("FAIL nonb_count: got %0d want 9", gotWords.size()); end
    foreach (expWords[i]) begin
      nChecks++;
      if (i >= gotWords.size() || gotWords[i] !== expWords[i] || gotLast[i] !== expLast[i]) begin
        nFail++; $display("FAIL nonb_word%0d: got %h/%0b want %h/%0b", i, gotWords[i], gotLast[i], expWords[i], expLast[i]);
      end
    end
    nChecks++; if (qvReads != 0 || kchReads != 2) begin nFail++; $display("FAIL nonb_reads: got %0d/%0d want 0/2", qvReads, kchReads); end
    nChecks++; if (h != 1 || d != 14) begin nFail++; $display("FAIL nonb_timing: got %0d/%0d want 1/14", h, d); end
  endtask

  task automatic test_backpressure();
    int h, d;
    qvVals = '{16'd7, 16'd3}; kchVals = '{16'hBEEF};
    randomFields(); patIdx = 0; readyMode = 1; startPacket(); waitDone(h, d);
    readyMode = 0;
    foreach (expWords[i]) begin
      nChecks++;
      if (i >= gotWords.size() || gotWords[i] !== expWords[i] || gotLast[i] !== expLast[i]) begin
        nFail++; $display("FAIL bp_word%0d: got %h/%0b want %h/%0b", i, gotWords[i], gotLast[i], expWords[i], expLast[i]);
      end
    end
    nChecks++; if (stabErr != 0) begin nFail++; $display("FAIL bp_stable: got %0d unstable holds want 0", stabErr); end
    nChecks++; if (doneCount != 1) begin nFail++; $display("FAIL bp_done: got %0d pulses want 1", doneCount); end
  endtask

  task automatic test_en_during_hdr();
    int h, d;
    logic [15:0] firstExp[$];
    qvVals = '{16'd1, 16'd2}; kchVals = '{16'd77};
    randomFields(); startPacket();
    firstExp = expWords;
    repeat (6) @(posedge clk);
    #1;
    nChecks++; if (tx_valid !== 1'b1) begin nFail++; $display("FAIL enhdr_in_hdr: got valid %b want 1", tx_valid); end
    @(negedge clk); myID = myID ^ 16'h5A5A; pktType = pktType ^ 3'd5; en = 1'b1;
    @(posedge clk); #1; en = 1'b0;
    waitDone(h, d);
    nChecks++; if (gotWords.size() != 8 || doneCount != 1) begin nFail++; $display("FAIL enhdr_one_pkt: got %0d words %0d done want 8 1", gotWords.size(), doneCount); end
    nChecks++; if (gotWords[0] !== firstExp[0] || gotWords[1] !== firstExp[1]) begin nFail++; $display("FAIL enhdr_fields: got %h %h want %h %h", gotWords[0], gotWords[1], firstExp[0], firstExp[1]); end
    qvVals = {}; kchVals = {};
    startPacket(); waitDone(h, d);
    foreach (expWords[i]) begin
      nChecks++;
      if (i >= gotWords.size() || gotWords[i] !== expWords[i] || gotLast[i] !== expLast[i]) begin
        nFail++; $display("FAIL enhdr_fresh%0d: got %h/%0b want %h/%0b", i, gotWords[i], gotLast[i], expWords[i], expLast[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int m;
    qvVals = '{16'd4}; kchVals = '{16'd11, 16'd22, 16'd33};
    randomFields(); startPacket();
    m = 0;
    while (gotWords.size() < 8 && m < 200) begin @(posedge clk); #1; m++; end
    readyMode = 3; tx_ready = 1'b0;
    m = 0;
    while (!tx_valid && m < 200) begin @(posedge clk); #1; m++; end
    nChecks++; if (tx_valid !== 1'b1 || gotWords.size() != 8) begin nFail++; $display("FAIL rmid_reach_send: got valid %b words %0d want 1 8", tx_valid, gotWords.size()); end
    @(negedge clk); nrst = 1'b0;
    @(posedge clk); #1;
    nChecks++; if (tx_valid !== 1'b0 || tx_last !== 1'b0 || tx_data !== 16'h0) begin nFail++; $display("FAIL rmid_tx: got %b %b %h want 0 0 0000", tx_valid, tx_last, tx_data); end
    nChecks++; if (mem_rd_en !== 1'b0 || mem_addr !== 11'h0) begin nFail++; $display("FAIL rmid_mem: got %b %h want 0 000", mem_rd_en, mem_addr); end
    nChecks++; if (bestQ !== 16'h0 || bestIdx !== 16'hFFFF) begin nFail++; $display("FAIL rmid_best: got %h@%h want 0000@ffff", bestQ, bestIdx); end
    nChecks++; if (busy !== 1'b0 || done !== 1'b0) begin nFail++; $display("FAIL rmid_busy: got %b%b want 00", busy, done); end
    @(negedge clk); nrst = 1'b1; readyMode = 0;
    repeat (20) @(posedge clk);
    #1;
    nChecks++; if (doneCount != 0 || busy !== 1'b0) begin nFail++; $display("FAIL rmid_no_done: got %0d pulses busy %b want 0 0", doneCount, busy); end
  endtask

  task automatic test_unsigned();
    int h, d;
    qvVals = '{16'hFFFF, 16'h0000}; kchVals = {};
    randomFields(); startPacket(); waitDone(h, d);
    nChecks++; if (bestQ !== 16'hFFFF || bestIdx !== 16'h0) begin nFail++; $display("FAIL unsigned_best: got %h@%h want ffff@0000", bestQ, bestIdx); end
    nChecks++; if (gotWords.size() < 6 || gotWords[5] !== 16'hFFFF) begin nFail++; $display("FAIL unsigned_word5: got %h want ffff", gotWords[5]); end
  endtask

  task automatic test_random();
    int h, d, n, k, mode;
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(0, 6); k = $urandom_range(0, 4); mode = (it % 2 == 0) ? 0 : 2;
      qvVals = {}; kchVals = {};
      for (int i = 0; i < n; i++) qvVals.push_back((it < 5) ? 16'($urandom_range(0, 3)) : 16'($urandom));
      for (int j = 0; j < k; j++) kchVals.push_back(16'($urandom));
      randomFields(); readyMode = mode; startPacket(); waitDone(h, d);
      readyMode = 0;
      nChecks++; if (bestQ !== expBestQ || bestIdx !== expBestIdx) begin nFail++; $display("FAIL rnd%0d_best: got %h@%h want %h@%h", it, bestQ, bestIdx, expBestQ, expBestIdx); end
      nChecks++; if (gotWords.size() != expWords.size()) begin nFail++; $display("FAIL rnd%0d_count: got %0d want %0d", it, gotWords.size(), expWords.size()); end
      foreach (expWords[i]) begin
        nChecks++;
        if (i >= gotWords.size() || gotWords[i] !== expWords[i] || gotLast[i] !== expLast[i]) begin
          nFail++; $display("FAIL rnd%0d_word%0d: got %h/%0b want %h/%0b", it, i, gotWords[i], gotLast[i], expWords[i], expLast[i]);
        end
      end
      nChecks++; if (doneCount != 1 || stabErr != 0 || rdErr != 0) begin nFail++; $display("FAIL rnd%0d_proto: got done %0d stab %0d rd %0d want 1 0 0", it, doneCount, stabErr, rdErr); end
      nChecks++; if (qvReads != n || kchReads != k) begin nFail++; $display("FAIL rnd%0d_reads: got %0d/%0d want %0d/%0d", it, qvReads, kchReads, n, k); end
      if (mode == 0) begin
        nChecks++; if (h != 1 + 2 * n || d != 1 + 2 * n + 7 + 3 * k) begin nFail++; $display("FAIL rnd%0d_timing: got %0d/%0d want %0d/%0d", it, h, d, 1 + 2 * n, 1 + 2 * n + 7 + 3 * k); end
      end
    end
  endtask

  initial begin
    nrst = 1'b0; en = 1'b0; pktType = 3'd0; myID = 16'h0; myHops = 16'h0;
    myClusterID = 16'h0; myEnergy = 16'h0; neighborCount = 16'h0; knownCHCount = 16'h0;
    for (int a = 0; a < 2048; a++) mem[a] = 16'(a * 7);
    clearMon();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); nrst = 1'b1;
    test_basic();
    test_no_neighbors();
    test_backpressure();
    test_en_during_hdr();
    test_reset_mid();
    test_unsigned();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
